data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 74 +++++++
 tb/tb_data_mem_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte/half/word data memory with zero-fill after reset, alignment/range errors and error counter
module data_mem_ctrl #(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err_align,
  output logic        err_range,
  output logic [7:0]  err_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t        r_state;
  logic [AW-1:0] r_clr_ptr;
  logic [31:0]   r_mem [DEPTH];
  logic          w_acc_rd, w_acc_wr, w_acc, w_mis, w_in_range, w_err, w_clr_en;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word, w_sh, w_rd_val, w_mask, w_wrep;
  // a request asserted together with reset is never accepted
  assign ready      = r_state == S_RUN;
  assign w_acc_rd   = req_rd & ready & ~reset;
  assign w_acc_wr   = req_wr & ready & ~reset;
  assign w_acc      = w_acc_rd | w_acc_wr;
  assign w_mis      = (size == 2'b11) | (size == 2'b01 & addr[0]) | (size == 2'b10 & |addr[1:0]);
  assign w_in_range = addr < 32'(4 * DEPTH);
  assign w_err      = w_mis | ~w_in_range;
  assign w_clr_en   = ~reset & (r_state == S_INIT) & CLEAR_ON_RESET;
  // out-of-range addresses are clamped to word 0; they never commit and read back as 0
  assign w_idx      = w_in_range ? addr[AW+1:2] : '0;
  assign w_word     = r_mem[w_idx];
  assign w_sh       = w_word >> {addr[1:0], 3'b000};
  assign w_rd_val   = size == 2'b00 ? {{24{sign_ext & w_sh[7]}}, w_sh[7:0]}
                    : size == 2'b01 ? {{16{sign_ext & w_sh[15]}}, w_sh[15:0]}
                    : w_word;
  assign w_mask     = size == 2'b00 ? 32'h0000_00FF << {addr[1:0], 3'b000}
                    : size == 2'b01 ? 32'h0000_FFFF << {addr[1], 4'b0000}
                    : '1;
  assign w_wrep     = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  // storage: zero-fill one word per cycle during INIT, otherwise masked lane write; not reset so contents survive reset
  always_ff @(posedge clk) begin
    if (w_clr_en) r_mem[r_clr_ptr] <= '0;
    else if (w_acc_wr && !w_err) r_mem[w_idx] <= (w_word & ~w_mask) | (w_wrep & w_mask);
  end
  // control FSM with registered read response, error pulses and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_clr_ptr <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err_align <= 1'b0;
      err_range <= 1'b0;
      err_count <= '0;
    end else begin
      r_state   <= (r_state == S_INIT && (CLEAR_ON_RESET == 1'b0 || r_clr_ptr == AW'(DEPTH - 1))) ? S_RUN : r_state;
      r_clr_ptr <= r_state == S_INIT ? r_clr_ptr + AW'(1) : r_clr_ptr;
      rvalid    <= w_acc_rd;
      rdata     <= w_acc_rd ? (w_err ? '0 : w_rd_val) : rdata;
      err_align <= w_acc & w_mis;
      err_range <= w_acc & ~w_mis & ~w_in_range;
      err_count <= (w_acc && w_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl with directed vectors
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset, req_rd, req_wr, sign_ext;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ready, rvalid, err_align, err_range;
  logic [31:0] rdata;
  logic [7:0]  err_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] d;
    logic        a;
    logic        r;
  } exp_t;
  exp_t q[$];

  data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata),
    .err_align(err_align), .err_range(err_range), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rvalid || err_align || err_range) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_response: got v=%0b d=%h a=%0b r=%0b, want none", rvalid, rdata, err_align, err_range);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rvalid !== e.v || err_align !== e.a || err_range !== e.r || (e.v && rdata !== e.d)) begin
          n_bad++;
          $display("FAIL %s: got v=%0b d=%h a=%0b r=%0b, want v=%0b d=%h a=%0b r=%0b",
                   e.nm, rvalid, rdata, err_align, err_range, e.v, e.d, e.a, e.r);
        end
      end
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endfunction

  // drive one request for one cycle; a response expectation is queued when one is due
  task automatic issue(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic se, input logic [31:0] wd,
                       input logic ev, input logic [31:0] ed, input logic ea, input logic er);
    exp_t e;
    req_rd = rd; req_wr = wr; addr = a; size = sz; sign_ext = se; wdata = wd;
    if (ev || ea || er) begin
      e.nm = nm; e.v = ev; e.d = ed; e.a = ea; e.r = er;
      q.push_back(e);
    end
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_drain"}, q.size(), 0);
  endtask

  task automatic wait_ready(input string nm, input int want);
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (nm == "init" && n == 10) begin
        req_rd = 1'b1; req_wr = 1'b1; addr = 32'h2; size = 2'b11;
      end
      if (n == 11) begin
        req_rd = 1'b0; req_wr = 1'b0;
      end
    end
    chk({nm, "_ready_cycles"}, n, want);
  endtask

  initial begin
    reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; addr = '0; size = '0; sign_ext = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_errs", {err_align, err_range}, 0);
    chk("rst_count", err_count, 0);
    reset = 1'b0;
    wait_ready("init", 256);
    chk("init_ignored_count", err_count, 0);
    issue("rd_3fc", 1, 0, 32'h3FC, 2'b10, 0, 0, 1, 32'h0, 0, 0);
    issue("wr_10", 0, 1, 32'h10, 2'b10, 0, 32'h8899AABB, 0, 0, 0, 0);
    issue("rd_b11_s", 1, 0, 32'h11, 2'b00, 1, 0, 1, 32'hFFFFFFAA, 0, 0);
    issue("rd_b13_z", 1, 0, 32'h13, 2'b00, 0, 0, 1, 32'h00000088, 0, 0);
    issue("rd_h12_s", 1, 0, 32'h12, 2'b01, 1, 0, 1, 32'hFFFF8899, 0, 0);
    issue("wr_20", 0, 1, 32'h20, 2'b10, 0, 32'h0, 0, 0, 0, 0);
    issue("wr_h22", 0, 1, 32'h22, 2'b01, 0, 32'hFFFF1234, 0, 0, 0, 0);
    issue("rd_20", 1, 0, 32'h20, 2'b10, 1, 0, 1, 32'h12340000, 0, 0);
    issue("wr_40", 0, 1, 32'h40, 2'b10, 0, 32'h1, 0, 0, 0, 0);
    issue("rdwr_40", 1, 1, 32'h40, 2'b10, 0, 32'h2, 1, 32'h1, 0, 0);
    issue("rd_40_new", 1, 0, 32'h40, 2'b10, 0, 0, 1, 32'h2, 0, 0);
    issue("wr_b43", 0, 1, 32'h43, 2'b00, 0, 32'h1234565A, 0, 0, 0, 0);
    issue("rd_40_lane", 1, 0, 32'h40, 2'b10, 0, 0, 1, 32'h5A000002, 0, 0);
    drain("basic");
    repeat (2) @(posedge clk);
    #1;
    chk("rdata_hold", rdata, 32'h5A000002);
    issue("rd_02_align", 1, 0, 32'h02, 2'b10, 0, 0, 1, 32'h0, 1, 0);
    drain("align");
    chk("count_1", err_count, 1);
    issue("wr_400_range", 0, 1, 32'h400, 2'b10, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    issue("rd_0_unchanged", 1, 0, 32'h0, 2'b10, 0, 0, 1, 32'h0, 0, 0);
    issue("rdwr_sz3", 1, 1, 32'h40, 2'b11, 0, 32'hFFFFFFFF, 1, 32'h0, 1, 0);
    issue("rd_top_range", 1, 0, 32'hFFFFFFFC, 2'b10, 0, 0, 1, 32'h0, 0, 1);
    issue("rd_402_both", 1, 0, 32'h402, 2'b10, 0, 0, 1, 32'h0, 1, 0);
    issue("rd_40_intact", 1, 0, 32'h40, 2'b10, 0, 0, 1, 32'h5A000002, 0, 0);
    drain("errs");
    chk("count_5", err_count, 5);
    for (int i = 0; i < 300; i++) issue("wr_mis_loop", 0, 1, 32'h41, 2'b01, 0, 0, 0, 0, 1, 0);
    drain("sat");
    chk("count_sat", err_count, 255);
    issue("rd_10_pre_rst", 1, 0, 32'h10, 2'b10, 0, 0, 1, 32'h8899AABB, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("run_rst_rvalid", rvalid, 0);
    chk("run_rst_ready", ready, 0);
    chk("run_rst_count", err_count, 0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_init_ready", ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready("reinit", 256);
    issue("rd_40_cleared", 1, 0, 32'h40, 2'b10, 0, 0, 1, 32'h0, 0, 0);
    drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
